// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Contents: operation encodings on the 3-bit op bus, FSM state encodings,
// and the LO value written by a divide by zero.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MULT  = 3'd1,
        OP_DIVU  = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_hilo_if.sv
// Request/response bundle between the pipeline controller and the HI/LO unit.
// master: controller side (drives start/op/a/b, observes busy/done/hi/lo/dz).
// slave:  muldiv_hilo side.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, dz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, dz
    );
endinterface

// File: rtl/muldiv_hilo_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
// Ports:
//   div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i : multiply -> {partial product, remaining multiplier bits}
//           divide   -> {partial remainder, remaining dividend bits}
//   opnd  : multiplicand (multiply) or divisor (divide), magnitudes only
//   acc_o : accumulator after this iteration (divide: bit 0 left clear)
//   qbit  : quotient bit produced by a divide step, 0 for multiply
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd : '0)};
        // Divide: bring the next dividend bit into a WIDTH+1-bit remainder.
        part = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        ge   = (part >= {1'b0, opnd});
        // When ge holds the true difference is below 2^WIDTH, so the
        // truncated subtraction is exact.
        diff = part[WIDTH-1:0] - opnd;

        if (div) begin
            qbit  = ge;
            acc_o = {(ge ? diff : part[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
        end else begin
            qbit  = 1'b0;
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit owning the CPU HI/LO registers.
// Executes MULTU, MULT, DIVU, DIV (ITER+2 cycles, busy asserted) and
// MTHI/MTLO (single edge, no busy/done).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of muldiv_hilo_if (start/op/a/b in; busy/done/hi/lo/dz out)
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_hilo_if.slave   bus
);
    localparam int CW = $clog2(ITER) + 1;

    state_t             state, state_nxt;
    op_t                op_r;
    logic               sa, sb, bz;
    logic [WIDTH-1:0]   a_org, opnd;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic               qbit;
    logic [CW-1:0]      cnt;

    logic               busy_d, done_d, load, wr_hi, wr_lo, step_en, finish;
    logic               req_calc, in_signed, in_div, sa_in, sb_in, is_div_r;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // Request decode
    assign req_calc  = bus.start && (bus.op <= 3'd3);
    assign in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign in_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    assign sa_in     = in_signed && bus.a[WIDTH-1];
    assign sb_in     = in_signed && bus.b[WIDTH-1];
    assign abs_a     = sa_in ? -bus.a : bus.a;
    assign abs_b     = sb_in ? -bus.b : bus.b;
    assign is_div_r  = (op_r == OP_DIVU) || (op_r == OP_DIV);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div   (is_div_r),
        .acc_i (acc),
        .opnd  (opnd),
        .acc_o (acc_step),
        .qbit  (qbit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_calc) state_nxt = ST_CALC;
            ST_CALC: if (cnt == CW'(ITER - 1)) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output/control decode; busy and done are registered from these
    always_comb begin
        load    = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        step_en = 1'b0;
        finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                load  = req_calc;
                wr_hi = bus.start && (bus.op == OP_MTHI);
                wr_lo = bus.start && (bus.op == OP_MTLO);
            end
            ST_CALC: step_en = 1'b1;
            ST_FIN:  finish  = 1'b1;
            default: ;
        endcase
        busy_d = (state_nxt != ST_IDLE);
        done_d = finish;
    end

    // Sign correction of the magnitude result
    always_comb begin
        prod_fix = (sa ^ sb) ? -acc : acc;
        q_fix    = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= OP_MULTU;
            sa       <= 1'b0;
            sb       <= 1'b0;
            bz       <= 1'b0;
            a_org    <= '0;
            opnd     <= '0;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.dz   <= 1'b0;
        end else begin
            bus.busy <= busy_d;
            bus.done <= done_d;

            if (load) begin
                op_r  <= op_t'(bus.op);
                sa    <= sa_in;
                sb    <= sb_in;
                a_org <= bus.a;
                bz    <= (bus.b == '0);
                cnt   <= '0;
                // Divide shifts the dividend out of the low half; multiply
                // shifts the multiplier out of it.
                if (in_div) begin
                    acc    <= {{WIDTH{1'b0}}, abs_a};
                    opnd   <= abs_b;
                    bus.dz <= 1'b0;
                end else begin
                    acc  <= {{WIDTH{1'b0}}, abs_b};
                    opnd <= abs_a;
                end
            end

            if (wr_hi) bus.hi <= bus.a;
            if (wr_lo) bus.lo <= bus.a;

            if (step_en) begin
                acc <= is_div_r ? {acc_step[2*WIDTH-1:1], qbit} : acc_step;
                cnt <= cnt + CW'(1);
            end

            if (finish) begin
                if (!is_div_r) begin
                    {bus.hi, bus.lo} <= prod_fix;
                end else if (bz) begin
                    bus.hi <= a_org;
                    bus.lo <= DIV0_LO;
                    bus.dz <= 1'b1;
                end else begin
                    bus.hi <= r_fix;
                    bus.lo <= q_fix;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_hilo_if #(.WIDTH(32)) bus();

    muldiv_hilo #(.WIDTH(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    res_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          ec, nb;
    logic        stable;
    logic [31:0] hi_ref, lo_ref;
    logic        dz_m = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference using plain 64-bit / signed arithmetic
    function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t               r;
        logic signed [63:0] sa64, sb64, sp;
        logic        [63:0] p;
        r = '0;
        case (op)
            3'd0: begin
                p = {32'b0, a} * {32'b0, b};
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            3'd1: begin
                sa64 = {{32{a[31]}}, a};
                sb64 = {{32{b[31]}}, b};
                sp = sa64 * sb64;
                r.hi = sp[63:32]; r.lo = sp[31:0];
            end
            3'd2: begin
                if (b == 0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin r.lo = a / b; r.hi = a % b; end
            end
            default: begin
                if (b == 0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.hi = 32'h0; r.lo = 32'h8000_0000;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
        endcase
        return r;
    endfunction

    // Drive one request for a single edge; optionally record its expected result
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        res_t e;
        if (push) begin
            e = model(op, a, b);
            if (op == 3'd2 || op == 3'd3) dz_m = (b == 0);
            e.dz = dz_m;
            sbq.push_back(e);
        end
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0;
        ec = 1;
        nb = bus.busy ? 1 : 0;
        hi_ref = bus.hi;
        lo_ref = bus.lo;
        stable = 1'b1;
    endtask

    task automatic step();
        tick();
        ec++;
        if (bus.busy) nb++;
        if (!bus.done && (bus.hi !== hi_ref || bus.lo !== lo_ref)) stable = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        res_t e;
        int   guard = 0;
        while (!bus.done && guard < 100) begin
            step();
            guard++;
        end
        check({tag, " done"}, 64'(bus.done), 64'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (bus.done) begin
                check({tag, " hi"}, 64'(bus.hi), 64'(e.hi));
                check({tag, " lo"}, 64'(bus.lo), 64'(e.lo));
                check({tag, " dz"}, 64'(bus.dz), 64'(e.dz));
                check({tag, " edges"}, 64'(ec), 64'd34);
                check({tag, " busy_cycles"}, 64'(nb), 64'd33);
                check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
                check({tag, " hilo_stable"}, 64'(stable), 64'd1);
            end
        end
    endtask

    initial begin
        logic        no_done;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;

        // Reset state
        tick(); tick();
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst hi",   64'(bus.hi),   64'd0);
        check("rst lo",   64'(bus.lo),   64'd0);
        check("rst dz",   64'(bus.dz),   64'd0);
        rst = 1'b0;
        tick();

        // MTHI then MTLO on consecutive cycles
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234_5678;
        tick();
        check("mthi hi",   64'(bus.hi),   64'h1234_5678);
        check("mthi done", 64'(bus.done), 64'd0);
        check("mthi busy", 64'(bus.busy), 64'd0);
        bus.op = 3'd5; bus.a = 32'h9ABC_DEF0;
        tick();
        bus.start = 1'b0;
        check("mtlo lo",   64'(bus.lo),   64'h9ABC_DEF0);
        check("mtlo hi",   64'(bus.hi),   64'h1234_5678);
        check("mtlo done", 64'(bus.done), 64'd0);

        // Reserved op is ignored
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'h5555_AAAA;
        tick();
        bus.start = 1'b0;
        check("rsvd busy", 64'(bus.busy), 64'd0);
        check("rsvd hilo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

        // Directed arithmetic; each send follows a done cycle (back-to-back)
        send(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done("multu_max");
        check("multu_max const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        send(3'd3, 32'hFFFF_FFF9, 32'd2, 1);         wait_done("div_m7_2");
        check("div_m7_2 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        send(3'd1, 32'hFFFF_FFFD, 32'd7, 1);         wait_done("mult_m3_7");
        check("mult_m3_7 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        send(3'd2, 32'd100, 32'd7, 1);               wait_done("divu_100_7");
        send(3'd2, 32'd5, 32'd0, 1);                 wait_done("divu_5_0");
        check("divu_5_0 const", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
        send(3'd2, 32'd9, 32'd3, 1);
        check("dz clear on accept", 64'(bus.dz), 64'd0);
        wait_done("divu_9_3");
        send(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("div_min_m1");
        send(3'd3, 32'hFFFF_FFF9, 32'd0, 1);         wait_done("div_m7_0");
        send(3'd1, 32'h8000_0000, 32'h8000_0000, 1); wait_done("mult_min_min");

        // MTHI while busy must be ignored
        send(3'd0, 32'd3, 32'd5, 1);
        step(); step(); step();
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF;
        step();
        bus.start = 1'b0;
        check("mthi_busy hi", 64'(bus.hi), 64'(hi_ref));
        wait_done("multu_3_5");

        // Random operations against the model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) rb = 32'hFFFF_FFFF;
            send(rop, ra, rb, 1);
            wait_done("rand");
        end

        // Reset in the middle of a MULT aborts it
        send(3'd1, 32'h0001_2345, 32'hFFFF_0003, 0);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        tick();
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort dz",   64'(bus.dz), 64'd0);
        rst = 1'b0;
        dz_m = 1'b0;
        no_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) no_done = 1'b0;
        end
        check("abort no_done", 64'(no_done), 64'd1);

        // Unit still usable after the abort
        send(3'd2, 32'd100, 32'd7, 1); wait_done("post_abort");
        check("scoreboard empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
Multi-cycle multiply/divide unit that owns the HI and LO registers of the 54-instruction MIPS CPU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It drives hi/lo directly into the downstream HI/LO/MUL writeback select stage that serves MFHI, MFLO and MUL. While an operation is in flight, busy stalls the pipeline controller.

Parameters:
WIDTH, 32, operand and HI/LO register width.
ITER, 32, iterations per mul/div; must equal WIDTH.

Ports:
clk  input  1  system clock; rising-edge.
rst  input  1  synchronous active-high reset.
start  input  1  request strobe; sampled every edge.
op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO; 6 and 7 reserved.
a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
b  input  WIDTH  rt operand: multiplier or divisor.
busy  output  1  unit occupied; new requests are ignored.
done  output  1  one-cycle pulse; hi/lo hold the new result in the same cycle.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
dz  output  1  sticky flag: last DIV/DIVU had b==0; cleared by the next accepted DIV/DIVU.

Behaviour:
- Reset, taking priority over everything, sets state=IDLE, busy=0, done=0, hi=0, lo=0, dz=0, iteration counter=0. Reset mid-operation aborts the operation and produces no done pulse.
- States: IDLE, CALC, FIN.
- IDLE:
  - start with op 0-3: latch a, b, op; latch sign flags for MULT/DIV; latch |a| and |b| for signed ops. Go to CALC with cnt=0.
  - start with op 4: hi<=a next edge. No busy, no done.
  - start with op 5: lo<=a next edge. No busy, no done.
  - start with op 6/7: ignored.
- CALC:
  - One radix-2 iteration per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, WIDTH+1-bit partial remainder.
  - cnt increments each cycle; after ITER iterations go to FIN.
- FIN: apply sign correction, write hi/lo, done=1 for this cycle only, return to IDLE.
- busy is a registered output: 1 in CALC and FIN, 0 otherwise. done is also registered.
- Latency: start sampled at edge t. busy=1 after edges t..t+ITER, i.e. 33 cycles. done=1 and hi/lo valid after edge t+ITER+1. busy=0 in that cycle, so a back-to-back start is accepted on the same cycle done is high.
- start while busy=1 is ignored for all ops, including MTHI/MTLO. The controller must hold the request until busy=0.
- Multiply results: {hi,lo}=a*b, full 64 bits. MULT is signed: negate the 64-bit product iff sign(a)^sign(b).
- Divide results: lo=quotient, hi=remainder.
  - DIV: quotient negated iff sign(a)^sign(b); remainder takes the sign of a (truncating division).
- DIV -2^31 / -1: lo=0x80000000 (wraps), hi=0. No flag.
- Divide by zero, DIVU or DIV: lo=0xFFFFFFFF, hi=a (original signed value), dz=1. Latency is unchanged.
- hi/lo change only at FIN, on MTHI/MTLO, or on reset. They are stable throughout CALC, so a concurrent MFHI/MFLO reads the old value. Hazard stalling belongs to the controller via busy.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings: OP_MULTU .. OP_MTLO.
  - state encodings: ST_IDLE, ST_CALC, ST_FIN.
  - constant DIV0_LO=32'hFFFFFFFF.
- Natural sub-module: muldiv_step. Combinational single iteration that takes accumulator/remainder, operand and mode, and returns the next accumulator/remainder plus the quotient bit. The FSM, counter, sign handling and HI/LO registers stay in muldiv_hilo.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 edges done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, dz=1. A following DIVU 9/3 clears dz, giving lo=3, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each, no done. MTHI issued during CALC is ignored and hi is unchanged.
- MULT started, rst asserted at iteration 10 -> next edge busy=0, hi=lo=0, no done. Back-to-back DIV issued on the done cycle of a previous MULTU is accepted.
